uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: line-level constants and receiver state encoding shared by the
// UART receiver and transmitter.
package uart_pkg;

    localparam logic IDLE_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // 2-of-3 vote used by the optional majority sampler
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
// Both flops reset to the idle line level so that reset release never
// looks like a falling edge to the receiver.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic m_axis_aclk,
    input  logic m_axis_aresetn,
    input  logic rx_bit,
    output logic rx_s
);

    logic rx_meta;

    // two-stage capture of the raw line
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            rx_meta <= IDLE_BIT;
            rx_s    <= IDLE_BIT;
        end else begin
            rx_meta <= rx_bit;
            rx_s    <= rx_meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with an AXI-Stream style single-entry output.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | line idle, waiting for rx_s to go low
// START     | timing to the middle of the start bit to confirm it
// DATA      | sampling 8 data bits, LSB first, one per bit period
// STOP      | sampling the stop bit; high delivers, low is a frame error
// WAIT_HIGH | after a frame error, waiting for the line to return high
//
// Optional build macro UART_RX_MAJORITY_EN: each sample is the 2-of-3 vote
// of rx_s at the sample point and the two preceding cycles (needs at least
// 4 clock cycles per bit). Without it, the single rx_s value is used.
//
// Reception never waits on m_axis_tready; a byte completing while the
// output still holds an unaccepted byte is dropped and flagged.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 0,
    parameter int BAUD_RATE     = 0
) (
    input  logic       m_axis_aclk,
    input  logic       m_axis_aresetn,
    input  logic       rx_bit,
    output logic       m_axis_tvalid,
    output logic [7:0] m_axis_tdata,
    input  logic       m_axis_tready,
    output logic       frame_err,
    output logic       overrun_err
);

    // a zero baud rate only occurs in an unconfigured instance; keep it elaborating
    localparam int BAUD_DIV    = (BAUD_RATE > 0) ? BAUD_RATE : 1;
    localparam int UART_CYCLES = CLOCK_FREQ_HZ / BAUD_DIV;
    localparam int HALF        = UART_CYCLES / 2;
    localparam int CNT_W       = (UART_CYCLES > 1) ? $clog2(UART_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UART_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    logic             rx_s;
    logic             sample;
    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             deliver;
    logic             frame_hit;

    uart_rx_sync u_sync (
        .m_axis_aclk    (m_axis_aclk),
        .m_axis_aresetn (m_axis_aresetn),
        .rx_bit         (rx_bit),
        .rx_s           (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1, rx_d2;

    // two-cycle history of the synchronized line for the majority vote
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            rx_d1 <= IDLE_BIT;
            rx_d2 <= IDLE_BIT;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    assign sample = majority3(rx_s, rx_d1, rx_d2);
`else
    assign sample = rx_s;
`endif

    // state, bit timer, bit index and shift register
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    // next-state, timer and sampling decisions
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        deliver   = 1'b0;
        frame_hit = 1'b0;
        case (state)
            IDLE: begin
                if (rx_s == START_BIT) begin
                    cnt_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == CNT_MID) begin
                    if (sample == START_BIT) begin
                        cnt_n     = '0;
                        bit_idx_n = '0;
                        state_n   = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    shreg_n   = {sample, shreg[7:1]};
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (sample == STOP_BIT) begin
                        deliver = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_hit = 1'b1;
                        state_n   = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s == IDLE_BIT) begin
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // output holding register, handshake and error pulses
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            frame_err     <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            frame_err   <= frame_hit;
            overrun_err <= 1'b0;
            if (deliver) begin
                if (m_axis_tvalid && !m_axis_tready) begin
                    // held byte wins; the fresh one is lost
                    overrun_err <= 1'b1;
                end else begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= shreg;
                end
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
